// File: rtl/sdram_arb_mc.sv
// -----------------------------------------------------------------------------
// sdram_arb_mc
//
// Multi-channel SDRAM arbiter with a built-in auto-refresh timer. It sits
// between the init/refresh/read/write engines and the command mux of the
// SDRAM controller. NCH user channels each raise a write and/or read request.
// One channel is granted at a time, either round-robin or fixed priority.
// A due refresh always pre-empts new grants, but it never interrupts a burst
// that is already in progress.
//
// Parameters
//   NCH         number of user channels (1..8)
//   REF_CYCLES  refresh interval in sclk cycles (minimum 4)
//   RR_MODE     1 = round-robin among channels, 0 = fixed priority (ch0 first)
//
// Ports
//   sclk        system clock; all logic runs on its rising edge
//   s_rst       synchronous active-high reset
//   init_done   level from the init engine; arbiter and timer idle while low
//   ch_wr_req   per-channel write request (level, held until granted)
//   ch_rd_req   per-channel read request (level, held until granted)
//   ch_grant    registered one-hot grant
//   grant_is_wr 1 = granted operation is a write; valid while ch_grant != 0
//   xfer_done   one-cycle pulse from the rd/wr engine when the burst ends
//   ref_start   one-cycle pulse to the refresh engine
//   ref_done    one-cycle pulse when the refresh completes
//   ref_overdue sticky flag: an interval expired with a refresh still pending
// -----------------------------------------------------------------------------
module sdram_arb_mc #(
    parameter int NCH        = 2,
    parameter int REF_CYCLES = 780,
    parameter bit RR_MODE    = 1'b1
) (
    input  logic           sclk,
    input  logic           s_rst,
    input  logic           init_done,
    input  logic [NCH-1:0] ch_wr_req,
    input  logic [NCH-1:0] ch_rd_req,
    output logic [NCH-1:0] ch_grant,
    output logic           grant_is_wr,
    input  logic           xfer_done,
    output logic           ref_start,
    input  logic           ref_done,
    output logic           ref_overdue
);

    localparam int TW = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(REF_CYCLES - 1);

    // Channel index width; one extra bit is used while scanning so that the
    // wrap-around of the round-robin pointer can be done with a subtract.
    localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [LW-1:0] LAST_RST = LW'(NCH - 1);
    localparam logic [LW:0]   NCH_EXT  = (LW + 1)'(NCH);

    typedef enum logic [1:0] {
        WAIT_INIT,
        ARB,
        REFRESH,
        XFER
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           refPending_q, refPending_d;
    logic           refOverdue_q, refOverdue_d;
    logic           refStart_q, refStart_d;
    logic [NCH-1:0] grant_q, grant_d;
    logic           isWr_q, isWr_d;
    logic [LW-1:0]  lastGrant_q, lastGrant_d;

    logic           timerWrap;
    logic           refAck;
    logic [NCH-1:0] reqVec;
    logic           winFound;
    logic [LW-1:0]  winIdx;
    logic           winIsWr;
    logic [NCH-1:0] winOneHot;
    logic [LW:0]    scanIdx;

    assign reqVec = ch_wr_req | ch_rd_req;

    // Refresh interval timer. It only runs once the SDRAM is initialised.
    // A wrap always (re)arms ref_pending; an acknowledge on the very same
    // edge is treated as belonging to the old interval, so the new interval
    // stays pending and no overdue is flagged.
    always_comb begin
        timerWrap    = init_done && (timer_q == TMAX);
        refAck       = (state_q == REFRESH) && ref_done;
        timer_d      = timer_q;
        refPending_d = refPending_q;
        refOverdue_d = refOverdue_q;

        if (init_done) begin
            timer_d = timerWrap ? '0 : timer_q + 1'b1;
        end

        if (timerWrap) begin
            refPending_d = 1'b1;
        end else if (refAck) begin
            refPending_d = 1'b0;
        end

        if (timerWrap && refPending_q && !refAck) begin
            refOverdue_d = 1'b1;
        end
    end

    // Winner selection. Round-robin scans from the channel after the last
    // one granted; fixed priority takes the lowest requesting index. Within
    // the winning channel a write beats a read.
    always_comb begin
        winFound  = 1'b0;
        winIdx    = '0;
        winIsWr   = 1'b0;
        winOneHot = '0;
        scanIdx   = '0;

        if (RR_MODE) begin
            for (int i = 0; i < NCH; i++) begin
                scanIdx = {1'b0, lastGrant_q} + (LW + 1)'(i + 1);
                if (scanIdx >= NCH_EXT) begin
                    scanIdx = scanIdx - NCH_EXT;
                end
                if (!winFound && reqVec[scanIdx[LW-1:0]]) begin
                    winFound = 1'b1;
                    winIdx   = scanIdx[LW-1:0];
                end
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!winFound && reqVec[i]) begin
                    winFound = 1'b1;
                    winIdx   = LW'(i);
                end
            end
        end

        for (int i = 0; i < NCH; i++) begin
            if (winFound && (LW'(i) == winIdx)) begin
                winOneHot[i] = 1'b1;
                winIsWr      = ch_wr_req[i];
            end
        end
    end

    // Arbiter FSM next-state and registered-output logic. The grant and the
    // refresh start pulse are computed here and registered, so they appear
    // one edge after the decision is made in ARB.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        isWr_d      = isWr_q;
        lastGrant_d = lastGrant_q;
        refStart_d  = 1'b0;

        case (state_q)
            WAIT_INIT: begin
                if (init_done) begin
                    state_d = ARB;
                end
            end

            ARB: begin
                if (refPending_q) begin
                    state_d    = REFRESH;
                    refStart_d = 1'b1;
                end else if (winFound) begin
                    state_d = XFER;
                    grant_d = winOneHot;
                    isWr_d  = winIsWr;
                    if (RR_MODE) begin
                        lastGrant_d = winIdx;
                    end
                end
            end

            XFER: begin
                if (xfer_done) begin
                    state_d = ARB;
                    grant_d = '0;
                    isWr_d  = 1'b0;
                end
            end

            REFRESH: begin
                if (ref_done) begin
                    state_d = ARB;
                end
            end

            default: begin
                state_d = WAIT_INIT;
                grant_d = '0;
                isWr_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset. The round-robin
    // pointer resets to the last channel so channel 0 is served first.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q      <= WAIT_INIT;
            timer_q      <= '0;
            refPending_q <= 1'b0;
            refOverdue_q <= 1'b0;
            refStart_q   <= 1'b0;
            grant_q      <= '0;
            isWr_q       <= 1'b0;
            lastGrant_q  <= LAST_RST;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            refPending_q <= refPending_d;
            refOverdue_q <= refOverdue_d;
            refStart_q   <= refStart_d;
            grant_q      <= grant_d;
            isWr_q       <= isWr_d;
            lastGrant_q  <= lastGrant_d;
        end
    end

    assign ch_grant    = grant_q;
    assign grant_is_wr = isWr_q;
    assign ref_start   = refStart_q;
    assign ref_overdue = refOverdue_q;

endmodule

// File: tb/tb_sdram_arb_mc.sv
// -----------------------------------------------------------------------------
// tb_sdram_arb_mc
//
// Self-checking bench for sdram_arb_mc. Three instances share the stimulus:
//   uRef : NCH=4, REF_CYCLES=8,  round-robin  (refresh timing scenarios)
//   uRr  : NCH=4, REF_CYCLES=64, round-robin  (arbitration, no refresh noise)
//   uFp  : NCH=4, REF_CYCLES=64, fixed priority
// Each scenario starts from reset and is a table of per-edge records holding
// the inputs driven before an edge and the outputs expected after it.
// -----------------------------------------------------------------------------
module tb_sdram_arb_mc;

    logic       sclk = 1'b0;
    logic       s_rst;
    logic       init_done;
    logic [3:0] chWrReq;
    logic [3:0] chRdReq;
    logic       xferDone;
    logic       refDone;

    logic [3:0] refGrant, rrGrant, fpGrant;
    logic       refIsWr, rrIsWr, fpIsWr;
    logic       refStart, rrStart, fpStart;
    logic       refOverdue, rrOverdue, fpOverdue;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic       rst;
        logic       init;
        logic [3:0] wr;
        logic [3:0] rd;
        logic       xd;
        logic       rdn;
        logic [3:0] expGrant;
        logic       expWr;
        logic       expRefStart;
        logic       expOverdue;
    } vec_t;

    vec_t vecs[$];

    always #5 sclk = ~sclk;

    sdram_arb_mc #(.NCH(4), .REF_CYCLES(8), .RR_MODE(1'b1)) uRef (
        .sclk(sclk), .s_rst(s_rst), .init_done(init_done),
        .ch_wr_req(chWrReq), .ch_rd_req(chRdReq),
        .ch_grant(refGrant), .grant_is_wr(refIsWr), .xfer_done(xferDone),
        .ref_start(refStart), .ref_done(refDone), .ref_overdue(refOverdue)
    );

    sdram_arb_mc #(.NCH(4), .REF_CYCLES(64), .RR_MODE(1'b1)) uRr (
        .sclk(sclk), .s_rst(s_rst), .init_done(init_done),
        .ch_wr_req(chWrReq), .ch_rd_req(chRdReq),
        .ch_grant(rrGrant), .grant_is_wr(rrIsWr), .xfer_done(xferDone),
        .ref_start(rrStart), .ref_done(refDone), .ref_overdue(rrOverdue)
    );

    sdram_arb_mc #(.NCH(4), .REF_CYCLES(64), .RR_MODE(1'b0)) uFp (
        .sclk(sclk), .s_rst(s_rst), .init_done(init_done),
        .ch_wr_req(chWrReq), .ch_rd_req(chRdReq),
        .ch_grant(fpGrant), .grant_is_wr(fpIsWr), .xfer_done(xferDone),
        .ref_start(fpStart), .ref_done(refDone), .ref_overdue(fpOverdue)
    );

    function automatic void addVec(input logic rst, input logic init,
                                   input logic [3:0] wr, input logic [3:0] rd,
                                   input logic xd, input logic rdn,
                                   input logic [3:0] g, input logic w,
                                   input logic rs, input logic od);
        vec_t v;
        v.rst = rst; v.init = init; v.wr = wr; v.rd = rd; v.xd = xd; v.rdn = rdn;
        v.expGrant = g; v.expWr = w; v.expRefStart = rs; v.expOverdue = od;
        vecs.push_back(v);
    endfunction

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        s_rst     = v.rst;
        init_done = v.init;
        chWrReq   = v.wr;
        chRdReq   = v.rd;
        xferDone  = v.xd;
        refDone   = v.rdn;
    endtask

    task automatic checkOutput(input string name, input int step,
                               input logic [3:0] act, input logic [3:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s edge %0d: got %b, expected %b", name, step, act, exp);
        end
    endtask

    task automatic checkDut(input int sel, input string tag, input int step,
                            input logic [3:0] g, input logic w,
                            input logic rs, input logic od);
        logic [3:0] aG;
        logic       aW, aS, aO;
        case (sel)
            0:       begin aG = refGrant; aW = refIsWr; aS = refStart; aO = refOverdue; end
            1:       begin aG = rrGrant;  aW = rrIsWr;  aS = rrStart;  aO = rrOverdue;  end
            default: begin aG = fpGrant;  aW = fpIsWr;  aS = fpStart;  aO = fpOverdue;  end
        endcase
        checkOutput({tag, ".ch_grant"},    step, aG, g);
        checkOutput({tag, ".grant_is_wr"}, step, {3'b000, aW}, {3'b000, w});
        checkOutput({tag, ".ref_start"},   step, {3'b000, aS}, {3'b000, rs});
        checkOutput({tag, ".ref_overdue"}, step, {3'b000, aO}, {3'b000, od});
    endtask

    task automatic doReset(input string tag);
        s_rst = 1'b1; init_done = 1'b0; chWrReq = '0; chRdReq = '0;
        xferDone = 1'b0; refDone = 1'b0;
        tick();
        tick();
        checkDut(0, {tag, "_rst_ref"}, 0, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkDut(1, {tag, "_rst_rr"},  0, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkDut(2, {tag, "_rst_fp"},  0, 4'b0000, 1'b0, 1'b0, 1'b0);
        vecs.delete();
    endtask

    task automatic runTable(input int sel, input string tag);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            tick();
            checkDut(sel, tag, i + 1, vecs[i].expGrant, vecs[i].expWr,
                     vecs[i].expRefStart, vecs[i].expOverdue);
        end
    endtask

    initial begin
        logic [3:0] rrExp[16];
        logic [3:0] fpExp[11];

        // Periodic refresh with no traffic: pending at edge 8, ref_start after
        // edges 9/17/25, acknowledged three cycles later each time.
        doReset("refresh");
        for (int k = 1; k <= 28; k++) begin
            addVec(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0,
                   (k == 12 || k == 20 || k == 28),
                   4'b0000, 1'b0, (k == 9 || k == 17 || k == 25), 1'b0);
        end
        runTable(0, "refresh");

        // Round-robin with all four channels writing; burst ends two cycles
        // after each grant, leaving one idle ARB cycle between grants.
        doReset("rr");
        rrExp = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010,
                  4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000,
                  4'b0000, 4'b0001, 4'b0001, 4'b0000};
        for (int k = 1; k <= 16; k++) begin
            addVec(1'b0, 1'b1, 4'b1111, 4'b0000, (k % 3 == 1) && (k > 1), 1'b0,
                   rrExp[k-1], (rrExp[k-1] != 4'b0000), 1'b0, 1'b0);
        end
        runTable(1, "rr");

        // Fixed priority with ch1 and ch3 requesting; ch1 wins until it drops.
        doReset("fp");
        fpExp = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010,
                  4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
        for (int k = 1; k <= 11; k++) begin
            addVec(1'b0, 1'b1, (k <= 7) ? 4'b1010 : 4'b1000, 4'b0000,
                   (k == 4 || k == 7 || k == 10), 1'b0,
                   fpExp[k-1], (fpExp[k-1] != 4'b0000), 1'b0, 1'b0);
        end
        runTable(2, "fp");

        // ch2 asks for write and read together: write first, then the read.
        doReset("wrrd");
        addVec(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 4'b0000, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 4'b0000, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        runTable(1, "wrrd");

        // Long burst across the first wrap: refresh waits for xfer_done, then
        // beats ch0. Never acknowledged, so the next wrap flags overdue.
        // The xfer_done at edge 18 lands in REFRESH and must be ignored.
        doReset("overdue");
        for (int k = 1; k <= 20; k++) begin
            addVec(1'b0, 1'b1, 4'b0001, 4'b0000, (k == 12 || k == 18), 1'b0,
                   (k >= 2 && k <= 11) ? 4'b0001 : 4'b0000, (k >= 2 && k <= 11),
                   (k == 13), (k >= 16));
        end
        runTable(0, "overdue");

        // Wrap coincides with xfer_done (edge 8) and later with ref_done
        // (edge 16): refresh is re-entered at once and overdue stays clear.
        doReset("sameedge");
        for (int k = 1; k <= 22; k++) begin
            addVec(1'b0, 1'b1, 4'b0001, 4'b0000, (k == 8 || k == 22),
                   (k == 16 || k == 19),
                   ((k >= 2 && k <= 7) || k == 20 || k == 21) ? 4'b0001 : 4'b0000,
                   ((k >= 2 && k <= 7) || k == 20 || k == 21),
                   (k == 9 || k == 17), 1'b0);
        end
        runTable(0, "sameedge");

        // Reset in the middle of a ch2 burst, then all channels request:
        // the pointer must be back at its reset value so ch0 wins.
        doReset("midrst");
        s_rst = 1'b0; init_done = 1'b1; chWrReq = 4'b0100;
        tick();
        tick();
        checkDut(1, "midrst_grant", 2, 4'b0100, 1'b1, 1'b0, 1'b0);
        tick();
        checkDut(1, "midrst_hold", 3, 4'b0100, 1'b1, 1'b0, 1'b0);
        s_rst = 1'b1;
        tick();
        checkDut(1, "midrst_reset", 4, 4'b0000, 1'b0, 1'b0, 1'b0);
        s_rst = 1'b0; chWrReq = 4'b1111;
        tick();
        checkDut(1, "midrst_waitinit", 5, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        checkDut(1, "midrst_first", 6, 4'b0001, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
